// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the EXE stage: owns HI/LO, runs multi-cycle MULT and a
// restoring DIV, and commits results only when EXE retires the instruction.
module mdu_ctrl #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter logic [31:0] RESET_HILO = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [5:0]  md_op,
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    input  logic        rd_req,
    input  logic        rd_hi,
    input  logic        exe_fire,
    input  logic        flush,
    output logic        md_ready,
    output logic        busy,
    output logic [31:0] rd_data,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int unsigned CNT_W = ($clog2(MUL_CYCLES) > 5) ? $clog2(MUL_CYCLES) : 5;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(31);

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       hi_q, lo_q;
    logic [31:0]       res_hi_q, res_lo_q;
    logic [31:0]       op_a_q;     // multiplicand, or dividend shifting into quotient
    logic [31:0]       op_b_q;     // multiplier, or divisor magnitude
    logic [31:0]       rem_q;
    logic              sgn_q;
    logic              neg_quo_q, neg_rem_q;

    logic              is_mul, is_div;
    logic [31:0]       abs_a, abs_b;
    logic signed [63:0] mul_a64, mul_b64, prod;
    logic [32:0]       rem_sh;
    logic              q_bit;
    logic [31:0]       rem_nxt;

    assign is_mul = md_op[5] | md_op[4];
    assign is_div = md_op[3] | md_op[2];

    assign abs_a = (md_op[3] & src0[31]) ? -src0 : src0;
    assign abs_b = (md_op[3] & src1[31]) ? -src1 : src1;

    // Sign-extend only for MULT; the low 64 bits of the product are exact either way.
    assign mul_a64 = {{32{sgn_q & op_a_q[31]}}, op_a_q};
    assign mul_b64 = {{32{sgn_q & op_b_q[31]}}, op_b_q};
    assign prod    = mul_a64 * mul_b64;

    // One restoring step; a zero divisor always "fits", giving Q=all ones and R=dividend.
    assign rem_sh  = {rem_q, op_a_q[31]};
    assign q_bit   = (rem_sh >= {1'b0, op_b_q});
    assign rem_nxt = q_bit ? 32'(rem_sh - {1'b0, op_b_q}) : rem_sh[31:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (op_valid && is_mul) begin
                    state_d = StMul;
                end else if (op_valid && is_div) begin
                    state_d = StDiv;
                end
            end
            StMul:  if (cnt_q == MUL_LAST) state_d = StDone;
            StDiv:  if (cnt_q == DIV_LAST) state_d = StFix;
            StFix:  state_d = StDone;
            StDone: if (exe_fire) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        md_ready = 1'b0;
        busy     = 1'b1;
        unique case (state_q)
            StIdle: begin
                md_ready = ~(op_valid & (is_mul | is_div));
                busy     = 1'b0;
            end
            StDone:  md_ready = 1'b1;
            default: md_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            hi_q      <= RESET_HILO;
            lo_q      <= RESET_HILO;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rem_q     <= '0;
            sgn_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (op_valid && !flush) begin
                        if (is_mul) begin
                            op_a_q <= src0;
                            op_b_q <= src1;
                            sgn_q  <= md_op[5];
                            cnt_q  <= '0;
                        end else if (is_div) begin
                            op_a_q    <= abs_a;
                            op_b_q    <= abs_b;
                            rem_q     <= '0;
                            neg_quo_q <= md_op[3] & (src0[31] ^ src1[31]);
                            neg_rem_q <= md_op[3] & src0[31];
                            cnt_q     <= '0;
                        end else if (exe_fire) begin
                            if (md_op[1]) hi_q <= src0;
                            if (md_op[0]) lo_q <= src0;
                        end
                    end
                end
                StMul: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == MUL_LAST) begin
                        res_hi_q <= prod[63:32];
                        res_lo_q <= prod[31:0];
                    end
                end
                StDiv: begin
                    cnt_q  <= cnt_q + 1'b1;
                    rem_q  <= rem_nxt;
                    op_a_q <= {op_a_q[30:0], q_bit};
                end
                StFix: begin
                    res_lo_q <= neg_quo_q ? -op_a_q : op_a_q;
                    res_hi_q <= neg_rem_q ? -rem_q : rem_q;
                end
                StDone: begin
                    if (exe_fire && !flush) begin
                        hi_q <= res_hi_q;
                        lo_q <= res_lo_q;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    assign rd_data = rd_hi ? hi_q : lo_q;
    assign hi_out  = hi_q;
    assign lo_out  = lo_q;

    a_single_instr: assert property (@(posedge clk) disable iff (!rst_n) !(op_valid && rd_req))
        else $error("mdu_ctrl: op_valid and rd_req asserted together");
    a_onehot_op: assert property (@(posedge clk) disable iff (!rst_n) op_valid |-> $onehot(md_op))
        else $error("mdu_ctrl: md_op not one-hot while op_valid");

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, corner sequences, and random ops
// compared against an arithmetic reference model.
module tb_mdu_ctrl;

    localparam int MULC = 2;
    localparam logic [5:0] OP_MULT  = 6'b100000;
    localparam logic [5:0] OP_MULTU = 6'b010000;
    localparam logic [5:0] OP_DIV   = 6'b001000;
    localparam logic [5:0] OP_DIVU  = 6'b000100;
    localparam logic [5:0] OP_MTHI  = 6'b000010;
    localparam logic [5:0] OP_MTLO  = 6'b000001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [5:0]  md_op = '0;
    logic [31:0] src0 = '0;
    logic [31:0] src1 = '0;
    logic        rd_req = 1'b0;
    logic        rd_hi = 1'b0;
    logic        exe_fire = 1'b0;
    logic        flush = 1'b0;
    logic        md_ready, busy;
    logic [31:0] rd_data, hi_out, lo_out;

    int total = 0;
    int bad = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mdu_ctrl #(.MUL_CYCLES(MULC), .RESET_HILO(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .md_op(md_op), .src0(src0),
        .src1(src1), .rd_req(rd_req), .rd_hi(rd_hi), .exe_fire(exe_fire), .flush(flush),
        .md_ready(md_ready), .busy(busy), .rd_data(rd_data), .hi_out(hi_out), .lo_out(lo_out)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, b, hi, lo;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: returns {hi, lo} after the op retires, from plain arithmetic.
    function automatic logic [63:0] ref_model(input logic [5:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] ohi,
                                              input logic [31:0] olo);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        logic na, nb;
        logic [31:0] ua, ub, uq, ur, q, r;
        case (op)
            OP_MULT: begin
                sa = a; sb = b;
                sa = {{32{a[31]}}, a};
                sb = {{32{b[31]}}, b};
                p = sa * sb;
                return p;
            end
            OP_MULTU: begin
                p = {32'h0, a} * {32'h0, b};
                return p;
            end
            OP_DIV, OP_DIVU: begin
                na = (op == OP_DIV) && a[31];
                nb = (op == OP_DIV) && b[31];
                ua = na ? -a : a;
                ub = nb ? -b : b;
                uq = (ub == 0) ? 32'hFFFFFFFF : ua / ub;
                ur = (ub == 0) ? ua : ua % ub;
                q = (na ^ nb) ? -uq : uq;
                r = na ? -ur : ur;
                return {r, q};
            end
            OP_MTHI: return {a, olo};
            default: return {ohi, a};
        endcase
    endfunction

    function automatic int lat_of(input logic [5:0] op);
        if (op == OP_MULT || op == OP_MULTU) return MULC + 1;
        if (op == OP_DIV || op == OP_DIVU) return 34;
        return 0;
    endfunction

    // Issue one op, wait (bounded) for md_ready, hold in DONE, then retire and check HI/LO.
    task automatic issue(input string name, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold, input logic [31:0] ehi,
                         input logic [31:0] elo, input int elat);
        int lat;
        @(posedge clk); #1;
        op_valid = 1'b1; md_op = op; src0 = a; src1 = b;
        lat = 0;
        @(negedge clk);
        while (!md_ready && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({name, " latency"}, lat, elat);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            check({name, " held ready"}, {31'h0, md_ready}, 32'h1);
            check({name, " held hi"}, hi_out, m_hi);
            check({name, " held lo"}, lo_out, m_lo);
        end
        exe_fire = 1'b1;
        @(posedge clk); #1;
        exe_fire = 1'b0; op_valid = 1'b0; md_op = '0;
        m_hi = ehi; m_lo = elo;
        @(negedge clk);
        check({name, " hi"}, hi_out, m_hi);
        check({name, " lo"}, lo_out, m_lo);
        check({name, " busy"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int lat;
        vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 3};
        vecs[1]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       34};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34};
        vecs[3]  = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h1,        32'hFFFFFFFE, 3};
        vecs[4]  = '{OP_DIVU,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 34};
        vecs[5]  = '{OP_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'h1,        34};
        vecs[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 34};
        vecs[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        3};
        vecs[8]  = '{OP_MTHI,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,        0};
        vecs[9]  = '{OP_MTLO,  32'h0BADF00D, 32'h0,        32'hDEADBEEF, 32'h0BADF00D, 0};
        vecs[10] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 34};
        vecs[11] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset ready", {31'h0, md_ready}, 32'h1);
        check("reset hi", hi_out, 32'h0);
        check("reset lo", lo_out, 32'h0);

        for (int i = 0; i < 12; i++) begin
            issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0,
                  vecs[i].hi, vecs[i].lo, vecs[i].lat);
        end

        // Read port: same-cycle ready, combinational data.
        @(posedge clk); #1;
        rd_req = 1'b1; rd_hi = 1'b1;
        @(negedge clk);
        check("mfhi data", rd_data, m_hi);
        check("mfhi ready", {31'h0, md_ready}, 32'h1);
        @(posedge clk); #1 rd_hi = 1'b0;
        @(negedge clk);
        check("mflo data", rd_data, m_lo);
        @(posedge clk); #1 rd_req = 1'b0;

        // Long MEM stall in DONE: single commit only on fire.
        issue("stall", OP_DIVU, 32'd1000, 32'd9, 5, 32'd1, 32'd111, 34);
        @(posedge clk); @(negedge clk);
        check("stall recommit hi", hi_out, 32'd1);

        // Flush in DIV cycle 10 with a simultaneous fire: no write, back to idle.
        @(posedge clk); #1;
        op_valid = 1'b1; md_op = OP_DIVU; src0 = 32'd500; src1 = 32'd3;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("div busy", {31'h0, busy}, 32'h1);
        flush = 1'b1; exe_fire = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; exe_fire = 1'b0; op_valid = 1'b0; md_op = '0;
        @(negedge clk);
        check("flush busy", {31'h0, busy}, 32'h0);
        check("flush hi", hi_out, m_hi);
        check("flush lo", lo_out, m_lo);
        issue("post-flush", OP_MULTU, 32'hFFFFFFFF, 32'd2, 0, 32'h1, 32'hFFFFFFFE, 3);

        // Flush in DONE with fire: result discarded.
        @(posedge clk); #1;
        op_valid = 1'b1; md_op = OP_MULT; src0 = 32'd5; src1 = 32'd6;
        lat = 0;
        @(negedge clk);
        while (!md_ready && lat < 100) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check("done-flush latency", lat, MULC + 1);
        flush = 1'b1; exe_fire = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; exe_fire = 1'b0; op_valid = 1'b0; md_op = '0;
        @(negedge clk);
        check("done-flush hi", hi_out, m_hi);
        check("done-flush lo", lo_out, m_lo);
        check("done-flush busy", {31'h0, busy}, 32'h0);

        // Random ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [5:0]  op;
            logic [31:0] a, b;
            logic [63:0] e;
            op = 6'b000001 << $urandom_range(0, 5);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            e = ref_model(op, a, b, m_hi, m_lo);
            issue($sformatf("rand%0d op=%b", i, op), op, a, b, $urandom_range(0, 2),
                  e[63:32], e[31:0], lat_of(op));
        end

        // Reset in the middle of a MULT.
        @(posedge clk); #1;
        op_valid = 1'b1; md_op = OP_MULT; src0 = 32'd9; src1 = 32'd9;
        @(posedge clk); #1;
        op_valid = 1'b0; md_op = '0; rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        m_hi = '0; m_lo = '0;
        check("mid-reset busy", {31'h0, busy}, 32'h0);
        check("mid-reset ready", {31'h0, md_ready}, 32'h1);
        check("mid-reset hi", hi_out, 32'h0);
        check("mid-reset lo", lo_out, 32'h0);
        issue("post-reset", OP_DIVU, 32'd100, 32'd7, 0, 32'd2, 32'd14, 34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
